apb_mem_slave_v2: RTL and testbench
===================================

# apb_mem_slave_v2

Parametrised APB4 memory slave; successor to the fixed 256-word, zero-wait APB memory model. Adds configurable depth, base address, programmable wait states via `pready`, byte-lane write strobes and `pslverr` error signalling. Used as the generic register/memory target behind the APB bridge in block-level benches and in small subsystem RTL.

## Interface
- `ADDR_WIDTH`, 32, width of `paddr`.
- `DATA_WIDTH`, 32, data width; multiple of 8, one of 8/16/32/64.
- `DEPTH`, 256, number of `DATA_WIDTH` words; power of two, ≥2.
- `BASE_ADDR`, 0, byte address of word 0; aligned to `DEPTH*DATA_WIDTH/8`.
- `WAIT_STATES`, 0, extra access-phase cycles per transfer, 0..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `paddr`  in  ADDR_WIDTH  byte address.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `pwdata`  in  DATA_WIDTH  write data.
- `pstrb`  in  DATA_WIDTH/8  write byte strobes; ignored on reads.
- `prdata`  out  DATA_WIDTH  read data, valid only while `pready`=1 on a read.
- `pready`  out  1  transfer completes on the rising edge where `psel`&`penable`&`pready`.
- `pslverr`  out  1  error response, valid only while `pready`=1.

## Operation
- FSM states: IDLE, WAIT, READY.
  - IDLE: on `psel`=1 & `penable`=0, latch `paddr`/`pwrite` and decode. If `WAIT_STATES`=0 → READY, else → WAIT with counter = `WAIT_STATES`-1.
  - WAIT: counter decrements each cycle; at 0 → READY.
  - READY: `pready`=1. Next edge → IDLE.
  - WAIT/READY with `psel`=0: abort. → IDLE, no memory write, outputs return to 0.
- Decode:
  - byte offset = `paddr` − `BASE_ADDR`.
  - word index = offset >> log2(DATA_WIDTH/8).
  - Error if `paddr` < `BASE_ADDR`, index ≥ `DEPTH`, or low log2(DATA_WIDTH/8) address bits ≠ 0.
- Write, no error: on the completion edge, byte lane i of mem[index] ← `pwdata` lane i where `pstrb`[i]=1; other lanes unchanged. `pstrb`=0 is a legal no-op write.
- Write, error: memory untouched; `pslverr`=1 in the READY cycle.
- Read, no error: `prdata` = mem[index], registered on the edge entering READY.
- Read, error: `prdata`=0, `pslverr`=1.
- `pwdata` and `pstrb` are sampled at the completion edge, not at setup.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, FSM=IDLE, counter=0.
- Reset asserted mid-transfer: immediate return to IDLE with outputs 0; the pending write is dropped.
- Transfer length = 2 + `WAIT_STATES` cycles, measured from the setup cycle to the completion cycle inclusive.
- `pready`, `prdata` and `pslverr` are registered with no combinational path from inputs. They are 0 in IDLE and WAIT and asserted only in READY.
- Back-to-back: the cycle after completion may be a new setup phase. No idle cycle is required, and full throughput at `WAIT_STATES`=0 is one transfer per 2 cycles.
- Read-after-write to the same word in consecutive transfers returns the new data.
- `paddr`/`pwrite` changes during WAIT/READY are ignored; the setup-phase latch is used. Bench protocol checks flag such changes.

## Test plan
- Reset, then idle: all outputs 0.
- `WAIT_STATES`=0: write 0xDEADBEEF to addr 0x10 with `pstrb`=0xF, then read 0x10.
  - Each transfer completes in 2 cycles; read returns 0xDEADBEEF; `pslverr`=0.
- Partial write: write 0x11223344 to 0x20 (`pstrb`=0xF), then 0xAABBCCDD with `pstrb`=0x5.
  - Read 0x20 → 0x11BB33DD.
- `WAIT_STATES`=3: single read.
  - `pready` rises exactly 4 cycles after the setup cycle (5-cycle transfer); `prdata` is 0 before that.
- Errors, `DEPTH`=256, `BASE_ADDR`=0x1000:
  - Write to 0x1400 (out of range), 0x0FFC (below base) and 0x1002 (unaligned) each give `pslverr`=1.
  - Memory is unchanged; reads of the same addresses return 0 with `pslverr`=1.
- Abort and reset: drop `psel` during WAIT on a write to 0x1004.
  - FSM returns to IDLE and the word is unchanged.
  - `rst` pulse during a WAIT read forces all outputs to 0 within the same cycle.

Source files
------------

// File: rtl/apb_mem_slave_v2.sv
// apb_mem_slave_v2 -- APB4 memory slave with configurable depth, base address,
// wait states, byte strobes and pslverr. Response outputs are fully registered.
module apb_mem_slave_v2 #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);
   localparam int NB          = DATA_WIDTH / 8;
   localparam int LSB         = $clog2(NB);
   localparam int IDXW        = $clog2(DEPTH);
   localparam int RANGE_SHIFT = LSB + IDXW;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  wr_q;
   logic                  err_q;
   logic [IDXW-1:0]       idx_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDXW-1:0]       idx_d;
   logic                  err_d;
   logic                  setup;
   logic                  complete;

   // Address decode: offset from base, word index, and error conditions
   // (below base, beyond the last word, or not word aligned).
   always_comb begin
      offset = paddr - BASE_ADDR;
      idx_d  = offset[LSB +: IDXW];
      err_d  = (paddr < BASE_ADDR) ||
               ((offset >> RANGE_SHIFT) != '0) ||
               ((paddr & ALIGN_MASK) != '0);
   end

   assign setup    = (state == S_IDLE)  && psel && !penable;
   assign complete = (state == S_READY) && psel && penable;

   // Transfer FSM; the response is registered on the edge entering READY
   // and cleared on the edge leaving it (completion or abort).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         pready  <= 1'b0;
         prdata  <= '0;
         pslverr <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (setup) begin
                  wr_q  <= pwrite;
                  err_q <= err_d;
                  idx_q <= idx_d;
                  if (WAIT_STATES == 0) begin
                     state   <= S_READY;
                     pready  <= 1'b1;
                     pslverr <= err_d;
                     prdata  <= (err_d || pwrite) ? '0 : mem[idx_d];
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            S_WAIT: begin
               if (!psel) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else if (cnt == 4'd0) begin
                  state   <= S_READY;
                  pready  <= 1'b1;
                  pslverr <= err_q;
                  prdata  <= (err_q || wr_q) ? '0 : mem[idx_q];
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_READY: begin
               state   <= S_IDLE;
               pready  <= 1'b0;
               pslverr <= 1'b0;
               prdata  <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Byte-lane write on the completion edge; pwdata/pstrb are taken here,
   // not at setup. Errored or aborted writes never reach the array.
   always_ff @(posedge clk) begin
      if (complete && wr_q && !err_q) begin
         for (int i = 0; i < NB; i++) begin
            if (pstrb[i]) mem[idx_q][i*8 +: 8] <= pwdata[i*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_apb_mem_slave_v2.sv
// Bench for apb_mem_slave_v2: one zero-wait instance at base 0 and one
// three-wait instance at base 0x1000, checked against a word-array model.
module tb_apb_mem_slave_v2;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] paddr, pwdata;
   logic        psel0, psel3, penable, pwrite;
   logic [3:0]  pstrb;
   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3, pslverr0, pslverr3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m0 [256];
   logic [31:0] m3 [256];

   always #5 clk = ~clk;

   apb_mem_slave_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
                      .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel0), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
      .pready(pready0), .pslverr(pslverr0));

   apb_mem_slave_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
                      .BASE_ADDR(32'h1000), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel3), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
      .pready(pready3), .pslverr(pslverr3));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic rdy(input int w);
      return (w == 3) ? pready3 : pready0;
   endfunction
   function automatic logic [31:0] rdo(input int w);
      return (w == 3) ? prdata3 : prdata0;
   endfunction
   function automatic logic erro(input int w);
      return (w == 3) ? pslverr3 : pslverr0;
   endfunction

   // Error if below base, beyond 256 words, or not a multiple of 4 bytes.
   function automatic logic exp_err(input logic [31:0] addr, input logic [31:0] base);
      if (addr < base) return 1'b1;
      if ((addr - base) / 4 >= 256) return 1'b1;
      if (addr % 4 != 0) return 1'b1;
      return 1'b0;
   endfunction

   // One APB transfer starting at a falling edge. Setup carries wrong
   // pwdata/pstrb so only completion-edge sampling writes the right value.
   task automatic xfer(input int w, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rd, output logic err, output int cyc);
      psel0 = (w == 0); psel3 = (w == 3); penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = ~data; pstrb = ~strb;
      cyc = 1;
      for (int b = 0; b < 40; b++) begin
         @(negedge clk);
         penable = 1'b1; pwdata = data; pstrb = strb;
         cyc++;
         if (rdy(w)) break;
         chk("wait_prdata", rdo(w), 32'h0);
         chk("wait_pslverr", 32'(erro(w)), 32'h0);
      end
      if (!rdy(w)) chk("pready_timeout", 32'(rdy(w)), 32'h1);
      rd  = rdo(w);
      err = erro(w);
      @(negedge clk);
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   // Transfer plus comparison against the model; model updated on good writes.
   task automatic do_op(input int w, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input string tag);
      logic [31:0] base, rd, expd;
      logic        e, err;
      int          cyc, idx;
      base = (w == 3) ? 32'h1000 : 32'h0;
      e    = exp_err(addr, base);
      idx  = int'((addr - base) / 4);
      xfer(w, wr, addr, data, strb, rd, err, cyc);
      chk({tag, "_cycles"}, 32'(cyc), (w == 3) ? 32'd5 : 32'd2);
      chk({tag, "_pslverr"}, 32'(err), 32'(e));
      if (!wr) begin
         expd = e ? 32'h0 : ((w == 3) ? m3[idx] : m0[idx]);
         chk({tag, "_prdata"}, rd, expd);
      end else if (!e) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
               if (w == 3) m3[idx][8*i +: 8] = data[8*i +: 8];
               else        m0[idx][8*i +: 8] = data[8*i +: 8];
            end
         end
      end
   endtask

   logic [31:0] a, d;
   int          w, r, waited;

   initial begin
      rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      #1;
      chk("rst_pready0", 32'(pready0), 32'h0);
      chk("rst_pready3", 32'(pready3), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_prdata0", prdata0, 32'h0);
      chk("idle_prdata3", prdata3, 32'h0);
      chk("idle_pslverr0", 32'(pslverr0), 32'h0);
      chk("idle_pslverr3", 32'(pslverr3), 32'h0);

      // Define every word in both memories.
      for (int i = 0; i < 256; i++) begin
         do_op(0, 1'b1, 32'(i * 4), $urandom, 4'hF, "pre0");
         do_op(3, 1'b1, 32'h1000 + 32'(i * 4), $urandom, 4'hF, "pre3");
      end

      // Full and partial writes, zero wait states.
      do_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_10");
      do_op(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_10");
      chk("rd_10_literal", m0[4], 32'hDEADBEEF);
      do_op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "wr_20");
      do_op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, "wr_20_part");
      do_op(0, 1'b0, 32'h20, 32'h0, 4'h0, "rd_20");
      chk("rd_20_literal", m0[8], 32'h11BB33DD);
      do_op(0, 1'b1, 32'h24, 32'h55555555, 4'h0, "wr_nostrb");
      do_op(0, 1'b0, 32'h24, 32'h0, 4'h0, "rd_nostrb");

      // Three wait states: read latency and errors.
      do_op(3, 1'b0, 32'h1010, 32'h0, 4'h0, "ws3_rd");
      do_op(3, 1'b1, 32'h1400, 32'hCAFEF00D, 4'hF, "err_oor_wr");
      do_op(3, 1'b1, 32'h0FFC, 32'hCAFEF00D, 4'hF, "err_below_wr");
      do_op(3, 1'b1, 32'h1002, 32'hCAFEF00D, 4'hF, "err_unal_wr");
      do_op(3, 1'b0, 32'h1400, 32'h0, 4'h0, "err_oor_rd");
      do_op(3, 1'b0, 32'h0FFC, 32'h0, 4'h0, "err_below_rd");
      do_op(3, 1'b0, 32'h1002, 32'h0, 4'h0, "err_unal_rd");
      do_op(3, 1'b0, 32'h1000, 32'h0, 4'h0, "err_word0");
      do_op(3, 1'b0, 32'h13FC, 32'h0, 4'h0, "err_wordlast");

      // Abort: drop psel in WAIT on a write to 0x1004.
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1004;
      pwdata = 32'h0BAD0BAD; pstrb = 4'hF;
      @(negedge clk); penable = 1'b1;
      @(negedge clk); psel3 = 1'b0; penable = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("abort_pready", 32'(pready3), 32'h0);
      end
      do_op(3, 1'b0, 32'h1004, 32'h0, 4'h0, "abort_rd");

      // Reset while READY on a write to 0x1008: outputs drop, write dropped.
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1008;
      pwdata = 32'h12345678; pstrb = 4'hF;
      waited = 0;
      @(negedge clk); penable = 1'b1;
      while (!pready3 && waited < 20) begin
         @(negedge clk); waited++;
      end
      chk("rstrdy_pready_seen", 32'(pready3), 32'h1);
      rst = 1'b1; #1;
      chk("rstrdy_pready", 32'(pready3), 32'h0);
      chk("rstrdy_pslverr", 32'(pslverr3), 32'h0);
      chk("rstrdy_prdata", prdata3, 32'h0);
      @(negedge clk); rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
      do_op(3, 1'b0, 32'h1008, 32'h0, 4'h0, "rstrdy_rd");

      // Reset during a WAIT read, then a full-length transfer follows.
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h100C;
      @(negedge clk); penable = 1'b1;
      @(negedge clk); rst = 1'b1; #1;
      chk("rstwait_pready", 32'(pready3), 32'h0);
      chk("rstwait_prdata", prdata3, 32'h0);
      @(negedge clk); rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
      do_op(3, 1'b0, 32'h100C, 32'h0, 4'h0, "rstwait_rd");

      // Random traffic on both instances.
      for (int n = 0; n < 150; n++) begin
         w = ($urandom_range(0, 1) == 1) ? 3 : 0;
         r = $urandom_range(0, 9);
         a = (w == 3) ? 32'h1000 : 32'h0;
         if (r < 7)       a = a + 32'($urandom_range(0, 255) * 4);
         else if (r == 7) a = a + 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
         else if (r == 8) a = a + 32'h400 + 32'($urandom_range(0, 63) * 4);
         else             a = (w == 3) ? 32'h1000 - 32'($urandom_range(1, 16) * 4)
                                       : 32'hFFFF_F000 + 32'($urandom_range(0, 63) * 4);
         d = $urandom;
         do_op(w, 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
